// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until both operands are known,
// snoops the ALU and LSB result buses, and issues the lowest-index ready entry each cycle.
`timescale 1ns/1ps
module alu_rs #(
   parameter int RS_SIZE  = 8,
   parameter int ROB_ID_W = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                need_flush_in,
   input  logic                dispatch_valid_in,
   input  logic [2:0]          dispatch_op_L1_in,
   input  logic                dispatch_op_L2_in,
   input  logic                dispatch_is_I_type_in,
   input  logic [ROB_ID_W-1:0] dispatch_rob_id_in,
   input  logic [31:0]         dispatch_vj_in,
   input  logic [31:0]         dispatch_vk_in,
   input  logic                dispatch_qj_busy_in,
   input  logic                dispatch_qk_busy_in,
   input  logic [ROB_ID_W-1:0] dispatch_qj_in,
   input  logic [ROB_ID_W-1:0] dispatch_qk_in,
   input  logic                alu_cdb_ready_in,
   input  logic [31:0]         alu_cdb_value_in,
   input  logic [ROB_ID_W-1:0] alu_cdb_rob_id_in,
   input  logic                lsb_cdb_ready_in,
   input  logic [31:0]         lsb_cdb_value_in,
   input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id_in,
   output logic                full_out,
   output logic                alu_valid_out,
   output logic [31:0]         alu_opr1_out,
   output logic [31:0]         alu_opr2_out,
   output logic [ROB_ID_W-1:0] alu_rob_id_out,
   output logic [2:0]          alu_op_L1_out,
   output logic                alu_op_L2_out,
   output logic                alu_is_I_type_out
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]  busy_q, busy_d;
   logic [2:0]          op1_q [RS_SIZE];
   logic [2:0]          op1_d [RS_SIZE];
   logic                op2_q [RS_SIZE];
   logic                op2_d [RS_SIZE];
   logic                isi_q [RS_SIZE];
   logic                isi_d [RS_SIZE];
   logic [ROB_ID_W-1:0] rob_q [RS_SIZE];
   logic [ROB_ID_W-1:0] rob_d [RS_SIZE];
   logic [31:0]         vj_q  [RS_SIZE];
   logic [31:0]         vj_d  [RS_SIZE];
   logic [31:0]         vk_q  [RS_SIZE];
   logic [31:0]         vk_d  [RS_SIZE];
   logic                qjb_q [RS_SIZE];
   logic                qjb_d [RS_SIZE];
   logic                qkb_q [RS_SIZE];
   logic                qkb_d [RS_SIZE];
   logic [ROB_ID_W-1:0] qj_q  [RS_SIZE];
   logic [ROB_ID_W-1:0] qj_d  [RS_SIZE];
   logic [ROB_ID_W-1:0] qk_q  [RS_SIZE];
   logic [ROB_ID_W-1:0] qk_d  [RS_SIZE];

   logic                valid_q, valid_d;
   logic [31:0]         opr1_q, opr1_d;
   logic [31:0]         opr2_q, opr2_d;
   logic [ROB_ID_W-1:0] orob_q, orob_d;
   logic [2:0]          oop1_q, oop1_d;
   logic                oop2_q, oop2_d;
   logic                oisi_q, oisi_d;

   logic                dispatch_fire;
   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx;
   logic [IDX_W-1:0]    alloc_idx;

   // Returns {still_pending, value}; the ALU bus wins if both buses carry the tag.
   function automatic logic [32:0] wake_op(input logic pend, input logic [ROB_ID_W-1:0] tag,
                                           input logic [31:0] val);
      logic [32:0] r;
      r = {pend, val};
      if (pend) begin
         if (alu_cdb_ready_in && alu_cdb_rob_id_in == tag) begin
            r = {1'b0, alu_cdb_value_in};
         end else if (lsb_cdb_ready_in && lsb_cdb_rob_id_in == tag) begin
            r = {1'b0, lsb_cdb_value_in};
         end
      end
      return r;
   endfunction

   assign full_out          = &busy_q;
   assign dispatch_fire     = dispatch_valid_in && !full_out && !need_flush_in && rdy_in;
   assign alu_valid_out     = valid_q;
   assign alu_opr1_out      = opr1_q;
   assign alu_opr2_out      = opr2_q;
   assign alu_rob_id_out    = orob_q;
   assign alu_op_L1_out     = oop1_q;
   assign alu_op_L2_out     = oop2_q;
   assign alu_is_I_type_out = oisi_q;

   // Descending scan so the lowest index is the last one written.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      alloc_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            alloc_idx = IDX_W'(i);
         end
         if (busy_q[i] && !qjb_q[i] && !qkb_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      busy_d  = busy_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      isi_d   = isi_q;
      rob_d   = rob_q;
      vj_d    = vj_q;
      vk_d    = vk_q;
      qjb_d   = qjb_q;
      qkb_d   = qkb_q;
      qj_d    = qj_q;
      qk_d    = qk_q;
      valid_d = 1'b0;
      opr1_d  = opr1_q;
      opr2_d  = opr2_q;
      orob_d  = orob_q;
      oop1_d  = oop1_q;
      oop2_d  = oop2_q;
      oisi_d  = oisi_q;
      if (!rdy_in) begin
         busy_d = busy_q;
      end else if (need_flush_in) begin
         busy_d = '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
               {qjb_d[i], vj_d[i]} = wake_op(qjb_q[i], qj_q[i], vj_q[i]);
               {qkb_d[i], vk_d[i]} = wake_op(qkb_q[i], qk_q[i], vk_q[i]);
            end
         end
         // Selection looks only at registered readiness, so fresh wakeups wait a cycle.
         if (sel_found) begin
            busy_d[sel_idx] = 1'b0;
            valid_d         = 1'b1;
            opr1_d          = vj_q[sel_idx];
            opr2_d          = vk_q[sel_idx];
            orob_d          = rob_q[sel_idx];
            oop1_d          = op1_q[sel_idx];
            oop2_d          = op2_q[sel_idx];
            oisi_d          = isi_q[sel_idx];
         end
         if (dispatch_fire) begin
            busy_d[alloc_idx] = 1'b1;
            op1_d[alloc_idx]  = dispatch_op_L1_in;
            op2_d[alloc_idx]  = dispatch_op_L2_in;
            isi_d[alloc_idx]  = dispatch_is_I_type_in;
            rob_d[alloc_idx]  = dispatch_rob_id_in;
            qj_d[alloc_idx]   = dispatch_qj_in;
            qk_d[alloc_idx]   = dispatch_qk_in;
            {qjb_d[alloc_idx], vj_d[alloc_idx]} =
               wake_op(dispatch_qj_busy_in, dispatch_qj_in, dispatch_vj_in);
            {qkb_d[alloc_idx], vk_d[alloc_idx]} =
               wake_op(dispatch_qk_busy_in, dispatch_qk_in, dispatch_vk_in);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q  <= '0;
         valid_q <= 1'b0;
         opr1_q  <= '0;
         opr2_q  <= '0;
         orob_q  <= '0;
         oop1_q  <= '0;
         oop2_q  <= 1'b0;
         oisi_q  <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         valid_q <= valid_d;
         opr1_q  <= opr1_d;
         opr2_q  <= opr2_d;
         orob_q  <= orob_d;
         oop1_q  <= oop1_d;
         oop2_q  <= oop2_d;
         oisi_q  <= oisi_d;
      end
   end

   // Entry payload is qualified by busy_q, so it needs no reset.
   always_ff @(posedge clk_in) begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      isi_q <= isi_d;
      rob_q <= rob_d;
      vj_q  <= vj_d;
      vk_q  <= vk_d;
      qjb_q <= qjb_d;
      qkb_q <= qkb_d;
      qj_q  <= qj_d;
      qk_q  <= qk_d;
   end

endmodule
